// File: rtl/waveform_pkg.sv
`default_nettype none
// ============================================================================
// Module   : waveform_pkg
// Purpose  : Shared constants for the waveform envelope scaler: ramp state
//            encodings, envelope/amplitude reference values and the default
//            DAC output range.
// Revision : 1.0 - initial release
// ============================================================================
package waveform_pkg;

    // Ramp state encoding, also driven straight out on the ramp_state port.
    localparam logic [1:0] c_RAMP_IDLE = 2'd0;
    localparam logic [1:0] c_RAMP_UP   = 2'd1;
    localparam logic [1:0] c_RAMP_HOLD = 2'd2;
    localparam logic [1:0] c_RAMP_DOWN = 2'd3;

    // Envelope full scale (Q0.16) and unity gain (Q1.15).
    localparam logic [15:0] c_ENV_FULL  = 16'hFFFF;
    localparam logic [15:0] c_AMP_UNITY = 16'h8000;

    // Default signed DAC range.
    localparam int c_DAC_WIDTH = 14;
    localparam int c_DAC_MIN   = -(2 ** (c_DAC_WIDTH - 1));
    localparam int c_DAC_MAX   = (2 ** (c_DAC_WIDTH - 1)) - 1;

endpackage
`default_nettype wire

// File: rtl/waveform_envelope_scaler_ramp.sv
`default_nettype none
// ============================================================================
// Module   : envelope_ramp_fsm
// Purpose  : Generates the time-varying envelope: a prescaled tick drives a
//            four-state ramp machine (IDLE / RAMP_UP / HOLD / RAMP_DOWN) that
//            slews the envelope register between zero and full scale.
// Ports    : clk, aresetn           - clock, async active-low reset
//            ramp_enable            - 1 = ramp towards full scale, 0 = to zero
//            cfg_ramp_step          - envelope change per tick
//            cfg_ramp_prescale      - one tick every (N+1) clocks
//            env                    - current envelope, Q0.16
//            ramp_state             - current state code
//            ramp_done              - one-cycle pulse when a ramp completes
// Revision : 1.0 - initial release
// ============================================================================
module envelope_ramp_fsm
    import waveform_pkg::*;
#(
    parameter int ENV_WIDTH      = 16,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      ramp_enable,
    input  logic [ENV_WIDTH-1:0]      cfg_ramp_step,
    input  logic [PRESCALE_WIDTH-1:0] cfg_ramp_prescale,
    output logic [ENV_WIDTH-1:0]      env,
    output logic [1:0]                ramp_state,
    output logic                      ramp_done
);

    localparam logic [ENV_WIDTH-1:0] c_ENV_MAX  = '1;
    localparam logic [ENV_WIDTH-1:0] c_ENV_ZERO = '0;

    logic [1:0]                r_state;
    logic [ENV_WIDTH-1:0]      r_env;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic                      r_done;

    logic [1:0]                w_state_nxt;
    logic [ENV_WIDTH-1:0]      w_env_nxt;
    logic                      w_done_nxt;
    logic                      w_tick;
    logic                      w_ramping;
    // One extra bit so overflow / borrow is visible instead of wrapping.
    logic [ENV_WIDTH:0]        w_env_up;
    logic [ENV_WIDTH:0]        w_env_dn;

    always_comb begin
        w_ramping   = (r_state == c_RAMP_UP) || (r_state == c_RAMP_DOWN);
        w_tick      = w_ramping && (r_presc == cfg_ramp_prescale);
        w_env_up    = {1'b0, r_env} + {1'b0, cfg_ramp_step};
        w_env_dn    = {1'b0, r_env} - {1'b0, cfg_ramp_step};
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_done_nxt  = 1'b0;

        case (r_state)
            c_RAMP_IDLE: begin
                w_env_nxt = c_ENV_ZERO;
                if (ramp_enable) begin
                    w_state_nxt = c_RAMP_UP;
                end
            end
            c_RAMP_UP: begin
                // Direction reversal wins over a tick: the new ramp starts
                // from the envelope exactly as it stands.
                if (!ramp_enable) begin
                    w_state_nxt = c_RAMP_DOWN;
                end else if (cfg_ramp_step == c_ENV_ZERO) begin
                    // Zero step means an instant switch, independent of tick.
                    w_env_nxt   = c_ENV_MAX;
                    w_state_nxt = c_RAMP_HOLD;
                    w_done_nxt  = 1'b1;
                end else if (w_tick) begin
                    if (w_env_up >= {1'b0, c_ENV_MAX}) begin
                        w_env_nxt   = c_ENV_MAX;
                        w_state_nxt = c_RAMP_HOLD;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_env_nxt = w_env_up[ENV_WIDTH-1:0];
                    end
                end
            end
            c_RAMP_HOLD: begin
                w_env_nxt = c_ENV_MAX;
                if (!ramp_enable) begin
                    w_state_nxt = c_RAMP_DOWN;
                end
            end
            default: begin // c_RAMP_DOWN
                if (ramp_enable) begin
                    w_state_nxt = c_RAMP_UP;
                end else if (cfg_ramp_step == c_ENV_ZERO) begin
                    w_env_nxt   = c_ENV_ZERO;
                    w_state_nxt = c_RAMP_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_tick) begin
                    // Borrow bit set means the step overshot zero.
                    if (w_env_dn[ENV_WIDTH] || (w_env_dn[ENV_WIDTH-1:0] == c_ENV_ZERO)) begin
                        w_env_nxt   = c_ENV_ZERO;
                        w_state_nxt = c_RAMP_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_env_nxt = w_env_dn[ENV_WIDTH-1:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= c_RAMP_IDLE;
            r_env   <= c_ENV_ZERO;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_env   <= w_env_nxt;
            r_done  <= w_done_nxt;
            // Every state change restarts the tick period from zero.
            if ((w_state_nxt != r_state) || !w_ramping || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESCALE_WIDTH'(1);
            end
        end
    end

    assign env        = r_env;
    assign ramp_state = r_state;
    assign ramp_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/waveform_envelope_scaler.sv
`default_nettype none
// ============================================================================
// Module   : waveform_envelope_scaler
// Purpose  : Scales generator samples by a static Q1.15 gain and a ramped
//            Q0.16 envelope, adds a DC offset and saturates to the DAC range.
//            Fixed three-stage pipeline, no backpressure.
// Ports    : clk, aresetn                 - clock, async active-low reset
//            s_axis_tdata/tvalid          - signed input samples
//            cfg_amplitude                - unsigned gain, Q1.15
//            cfg_offset                   - signed DC offset in DAC LSBs
//            cfg_ramp_step/prescale       - envelope slew controls
//            ramp_enable                  - ramp target select
//            m_axis_tdata/tvalid          - saturated, sign-extended output
//            ramp_state, ramp_done        - envelope status
// Revision : 1.0 - initial release
// ============================================================================
module waveform_envelope_scaler
    import waveform_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int DAC_WIDTH        = c_DAC_WIDTH,
    parameter int AMP_WIDTH        = 16,
    parameter int ENV_WIDTH        = 16,
    parameter int PRESCALE_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic [AMP_WIDTH-1:0]        cfg_amplitude,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_offset,
    input  logic [ENV_WIDTH-1:0]        cfg_ramp_step,
    input  logic [PRESCALE_WIDTH-1:0]   cfg_ramp_prescale,
    input  logic                        ramp_enable,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic [1:0]                  ramp_state,
    output logic                        ramp_done
);

    // Stage widths: S1 full product, S2 product after envelope multiply,
    // S3 one bit wider again so the offset add cannot overflow.
    localparam int c_P1_W   = AXIS_TDATA_WIDTH + AMP_WIDTH + 1;
    localparam int c_PROD_W = c_P1_W + ENV_WIDTH + 1;
    localparam int c_SUM_W  = c_PROD_W + 1;

    localparam logic signed [c_SUM_W-1:0] c_SAT_MAX = c_SUM_W'((2 ** (DAC_WIDTH - 1)) - 1);
    localparam logic signed [c_SUM_W-1:0] c_SAT_MIN = c_SUM_W'(-(2 ** (DAC_WIDTH - 1)));

    logic [ENV_WIDTH-1:0]               w_env;

    logic signed [c_P1_W-1:0]           w_tdata_x;
    logic signed [c_P1_W-1:0]           w_amp_x;
    logic signed [c_PROD_W-1:0]         w_p1_ext;
    logic signed [c_PROD_W-1:0]         w_p1_q;
    logic signed [c_PROD_W-1:0]         w_env_x;
    logic signed [c_PROD_W-1:0]         w_prod2;
    logic signed [c_SUM_W-1:0]          w_sum;
    logic [AXIS_TDATA_WIDTH-1:0]        w_sat;

    logic signed [c_P1_W-1:0]           r_p1;
    logic signed [c_PROD_W-1:0]         r_p2;
    logic [AXIS_TDATA_WIDTH-1:0]        r_out;
    logic                               r_v1;
    logic                               r_v2;
    logic                               r_v3;

    envelope_ramp_fsm #(
        .ENV_WIDTH      (ENV_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_ramp (
        .clk               (clk),
        .aresetn           (aresetn),
        .ramp_enable       (ramp_enable),
        .cfg_ramp_step     (cfg_ramp_step),
        .cfg_ramp_prescale (cfg_ramp_prescale),
        .env               (w_env),
        .ramp_state        (ramp_state),
        .ramp_done         (ramp_done)
    );

    always_comb begin
        // S1 operands: signed sample times zero-extended (always positive) gain.
        w_tdata_x = {{(c_P1_W - AXIS_TDATA_WIDTH){s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};
        w_amp_x   = {{(c_P1_W - AMP_WIDTH){1'b0}}, cfg_amplitude};

        // S2: drop the Q1.15 fraction (floor), then scale by the envelope.
        w_p1_ext  = {{(c_PROD_W - c_P1_W){r_p1[c_P1_W-1]}}, r_p1};
        w_p1_q    = w_p1_ext >>> (AMP_WIDTH - 1);
        w_env_x   = {{(c_PROD_W - ENV_WIDTH){1'b0}}, w_env};
        w_prod2   = w_p1_q * w_env_x;

        // S3: offset add and clamp. A clamped value fits DAC_WIDTH bits, so
        // its low AXIS_TDATA_WIDTH bits are already the sign-extended result.
        w_sum     = {r_p2[c_PROD_W-1], r_p2}
                  + {{(c_SUM_W - AXIS_TDATA_WIDTH){cfg_offset[AXIS_TDATA_WIDTH-1]}}, cfg_offset};
        if (w_sum > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[AXIS_TDATA_WIDTH-1:0];
        end else if (w_sum < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[AXIS_TDATA_WIDTH-1:0];
        end else begin
            w_sat = w_sum[AXIS_TDATA_WIDTH-1:0];
        end
    end

    // Data registers update every clock; valid simply travels alongside.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_p1  <= '0;
            r_p2  <= '0;
            r_out <= '0;
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
        end else begin
            r_p1  <= w_tdata_x * w_amp_x;
            r_p2  <= w_prod2 >>> ENV_WIDTH;
            r_out <= w_sat;
            r_v1  <= s_axis_tvalid;
            r_v2  <= r_v1;
            r_v3  <= r_v2;
        end
    end

    assign m_axis_tdata  = r_out;
    assign m_axis_tvalid = r_v3;

endmodule
`default_nettype wire

// File: tb/tb_waveform_envelope_scaler.sv
`default_nettype none
// ============================================================================
// Module   : tb_waveform_envelope_scaler
// Purpose  : Directed self-checking bench for waveform_envelope_scaler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_waveform_envelope_scaler;
    import waveform_pkg::*;

    logic               clk;
    logic               aresetn;
    logic signed [15:0] s_axis_tdata;
    logic               s_axis_tvalid;
    logic [15:0]        cfg_amplitude;
    logic signed [15:0] cfg_offset;
    logic [15:0]        cfg_ramp_step;
    logic [15:0]        cfg_ramp_prescale;
    logic               ramp_enable;
    logic signed [15:0] m_axis_tdata;
    logic               m_axis_tvalid;
    logic [1:0]         ramp_state;
    logic               ramp_done;

    int total = 0;
    int bad   = 0;

    waveform_envelope_scaler dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .cfg_amplitude     (cfg_amplitude),
        .cfg_offset        (cfg_offset),
        .cfg_ramp_step     (cfg_ramp_step),
        .cfg_ramp_prescale (cfg_ramp_prescale),
        .ramp_enable       (ramp_enable),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .ramp_state        (ramp_state),
        .ramp_done         (ramp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; observe/drive 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic to_idle();
        cfg_ramp_step     = 16'h0000;
        cfg_ramp_prescale = 16'd0;
        ramp_enable       = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) cyc();
        total++; if (m_axis_tdata !== 16'sd0) begin bad++; $display("FAIL reset_tdata got=%0d exp=0", m_axis_tdata); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        total++; if (ramp_state !== c_RAMP_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", ramp_state); end
        total++; if (ramp_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", ramp_done); end
        aresetn = 1'b1;
        cyc();
    endtask

    task automatic test_unity();
        cfg_amplitude = c_AMP_UNITY; cfg_offset = 16'sd0;
        cfg_ramp_step = 16'h0000; cfg_ramp_prescale = 16'd0;
        s_axis_tdata = 16'sd0; s_axis_tvalid = 1'b1; ramp_enable = 1'b1;
        cyc(); cyc();
        total++; if (ramp_state !== c_RAMP_HOLD) begin bad++; $display("FAIL unity_hold got=%0d exp=2", ramp_state); end
        repeat (3) cyc();
        s_axis_tdata = 16'sd4000;
        cyc(); cyc();
        total++; if (m_axis_tdata !== 16'sd0) begin bad++; $display("FAIL unity_early got=%0d exp=0", m_axis_tdata); end
        cyc();
        total++; if (m_axis_tdata !== 16'sd3999) begin bad++; $display("FAIL unity_pos got=%0d exp=3999", m_axis_tdata); end
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL unity_valid got=%b exp=1", m_axis_tvalid); end
        s_axis_tdata = -16'sd4000;
        repeat (3) cyc();
        total++; if (m_axis_tdata !== -16'sd4000) begin bad++; $display("FAIL unity_neg got=%0d exp=-4000", m_axis_tdata); end
    endtask

    task automatic test_saturation();
        logic signed [15:0] din [4]  = '{16'sd16000, -16'sd16000, 16'sd0, 16'sd100};
        logic signed [15:0] offs [4] = '{16'sd0, 16'sd0, -16'sd9000, 16'sd8100};
        logic signed [15:0] exp [4]  = '{16'sd8191, -16'sd8192, -16'sd8192, 16'sd8191};
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = din[i]; cfg_offset = offs[i];
            repeat (3) cyc();
            total++; if (m_axis_tdata !== exp[i]) begin bad++; $display("FAIL sat_%0d got=%0d exp=%0d", i, m_axis_tdata, exp[i]); end
        end
        cfg_offset = 16'sd0;
    endtask

    task automatic test_step_zero_down();
        cfg_ramp_step = 16'h0000; ramp_enable = 1'b0;
        cyc();
        total++; if (ramp_state !== c_RAMP_DOWN) begin bad++; $display("FAIL sz_down got=%0d exp=3", ramp_state); end
        total++; if (dut.u_ramp.r_env !== 16'hFFFF) begin bad++; $display("FAIL sz_env1 got=%h exp=ffff", dut.u_ramp.r_env); end
        cyc();
        total++; if (ramp_state !== c_RAMP_IDLE) begin bad++; $display("FAIL sz_idle got=%0d exp=0", ramp_state); end
        total++; if (dut.u_ramp.r_env !== 16'h0000) begin bad++; $display("FAIL sz_env2 got=%h exp=0000", dut.u_ramp.r_env); end
        total++; if (ramp_done !== 1'b1) begin bad++; $display("FAIL sz_done got=%b exp=1", ramp_done); end
        cyc();
        total++; if (ramp_done !== 1'b0) begin bad++; $display("FAIL sz_done_clr got=%b exp=0", ramp_done); end
    endtask

    task automatic test_idle_offset();
        logic signed [15:0] din [3]  = '{-16'sd32768, 16'sd32767, 16'sd1234};
        logic signed [15:0] offs [3] = '{-16'sd500, 16'sd10000, 16'sd0};
        logic signed [15:0] exp [3]  = '{-16'sd500, 16'sd8191, 16'sd0};
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = din[i]; cfg_offset = offs[i];
            repeat (3) cyc();
            total++; if (m_axis_tdata !== exp[i]) begin bad++; $display("FAIL idle_off_%0d got=%0d exp=%0d", i, m_axis_tdata, exp[i]); end
        end
        cfg_offset = 16'sd0;
    endtask

    task automatic test_ramp_up();
        logic [1:0]  st [6] = '{c_RAMP_UP, c_RAMP_UP, c_RAMP_UP, c_RAMP_UP, c_RAMP_HOLD, c_RAMP_HOLD};
        logic [15:0] ev [6] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hFFFF};
        logic        dn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        cfg_ramp_step = 16'h4000; cfg_ramp_prescale = 16'd0; ramp_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            total++; if (ramp_state !== st[i]) begin bad++; $display("FAIL up_state_%0d got=%0d exp=%0d", i, ramp_state, st[i]); end
            total++; if (dut.u_ramp.r_env !== ev[i]) begin bad++; $display("FAIL up_env_%0d got=%h exp=%h", i, dut.u_ramp.r_env, ev[i]); end
            total++; if (ramp_done !== dn[i]) begin bad++; $display("FAIL up_done_%0d got=%b exp=%b", i, ramp_done, dn[i]); end
        end
    endtask

    task automatic test_prescale();
        logic [15:0] ev [9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000,
                                16'h4000, 16'h4000, 16'h4000, 16'h8000};
        cfg_ramp_step = 16'h4000; cfg_ramp_prescale = 16'd3; ramp_enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            total++; if (dut.u_ramp.r_env !== ev[i]) begin bad++; $display("FAIL presc_env_%0d got=%h exp=%h", i, dut.u_ramp.r_env, ev[i]); end
        end
    endtask

    task automatic test_reversal();
        logic [1:0]         st [5] = '{c_RAMP_DOWN, c_RAMP_DOWN, c_RAMP_IDLE, c_RAMP_IDLE, c_RAMP_IDLE};
        logic [15:0]        ev [5] = '{16'h8000, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
        logic               dn [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic signed [15:0] ot [5] = '{16'sd1000, 16'sd2000, 16'sd2000, 16'sd1000, 16'sd0};
        cfg_amplitude = c_AMP_UNITY; cfg_offset = 16'sd0;
        s_axis_tdata = 16'sd4000; s_axis_tvalid = 1'b1;
        cfg_ramp_step = 16'h4000; cfg_ramp_prescale = 16'd0; ramp_enable = 1'b1;
        repeat (3) cyc();
        ramp_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++; if (ramp_state !== st[i]) begin bad++; $display("FAIL rev_state_%0d got=%0d exp=%0d", i, ramp_state, st[i]); end
            total++; if (dut.u_ramp.r_env !== ev[i]) begin bad++; $display("FAIL rev_env_%0d got=%h exp=%h", i, dut.u_ramp.r_env, ev[i]); end
            total++; if (ramp_done !== dn[i]) begin bad++; $display("FAIL rev_done_%0d got=%b exp=%b", i, ramp_done, dn[i]); end
            total++; if (m_axis_tdata !== ot[i]) begin bad++; $display("FAIL rev_out_%0d got=%0d exp=%0d", i, m_axis_tdata, ot[i]); end
        end
    endtask

    task automatic test_ramp_down_from_hold();
        logic signed [15:0] ot [7] = '{16'sd3999, 16'sd3999, 16'sd3999, 16'sd2999,
                                       16'sd1999, 16'sd999, 16'sd0};
        s_axis_tdata = 16'sd4000; s_axis_tvalid = 1'b1;
        cfg_ramp_step = 16'h0000; ramp_enable = 1'b1;
        cyc(); cyc();
        cfg_ramp_step = 16'h4000; ramp_enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i >= 2) begin
                total++; if (m_axis_tdata !== ot[i]) begin bad++; $display("FAIL down_out_%0d got=%0d exp=%0d", i, m_axis_tdata, ot[i]); end
            end
            if (i == 4) begin
                total++; if (ramp_state !== c_RAMP_IDLE) begin bad++; $display("FAIL down_idle got=%0d exp=0", ramp_state); end
                total++; if (ramp_done !== 1'b1) begin bad++; $display("FAIL down_done got=%b exp=1", ramp_done); end
            end
        end
    endtask

    task automatic test_valid();
        logic pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        cfg_offset = 16'sd123; s_axis_tdata = 16'sd77; s_axis_tvalid = 1'b0;
        repeat (4) cyc();
        for (int j = 0; j < 7; j++) begin
            s_axis_tvalid = pat[j];
            cyc();
            if (j >= 2) begin
                total++; if (m_axis_tvalid !== pat[j-2]) begin bad++; $display("FAIL valid_%0d got=%b exp=%b", j, m_axis_tvalid, pat[j-2]); end
                if (pat[j-2]) begin
                    total++; if (m_axis_tdata !== 16'sd123) begin bad++; $display("FAIL valid_data_%0d got=%0d exp=123", j, m_axis_tdata); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        cfg_offset = 16'sd300; s_axis_tdata = 16'sd4000; s_axis_tvalid = 1'b1;
        cfg_ramp_step = 16'h4000; cfg_ramp_prescale = 16'd0; ramp_enable = 1'b1;
        repeat (3) cyc();
        total++; if (dut.u_ramp.r_env !== 16'h8000) begin bad++; $display("FAIL rst_pre_env got=%h exp=8000", dut.u_ramp.r_env); end
        aresetn = 1'b0;
        #1;
        total++; if (m_axis_tdata !== 16'sd0) begin bad++; $display("FAIL rst_mid_tdata got=%0d exp=0", m_axis_tdata); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mid_tvalid got=%b exp=0", m_axis_tvalid); end
        total++; if (ramp_state !== c_RAMP_IDLE) begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", ramp_state); end
        total++; if (dut.u_ramp.r_env !== 16'h0000) begin bad++; $display("FAIL rst_mid_env got=%h exp=0000", dut.u_ramp.r_env); end
        ramp_enable = 1'b0;
        #2;
        aresetn = 1'b1;
        repeat (3) cyc();
        total++; if (m_axis_tdata !== 16'sd300) begin bad++; $display("FAIL rst_after_out got=%0d exp=300", m_axis_tdata); end
        total++; if (ramp_state !== c_RAMP_IDLE) begin bad++; $display("FAIL rst_after_state got=%0d exp=0", ramp_state); end
    endtask

    initial begin
        aresetn = 1'b0; s_axis_tdata = 16'sd0; s_axis_tvalid = 1'b0;
        cfg_amplitude = c_AMP_UNITY; cfg_offset = 16'sd0;
        cfg_ramp_step = 16'h0000; cfg_ramp_prescale = 16'd0; ramp_enable = 1'b0;

        test_reset();
        test_unity();
        test_saturation();
        test_step_zero_down();
        test_idle_offset();
        test_ramp_up();
        to_idle();
        test_prescale();
        to_idle();
        test_reversal();
        test_ramp_down_from_hold();
        test_valid();
        test_reset_mid_ramp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
